local_inject_arbiter: RTL and testbench

Round-robin injection arbiter that shares one router Local input port among `NUM_SRC` processing-element packet sources in the mesh NoC. It captures one 26-bit packet at a time from the winning source into a holding buffer. It then drives the router's Local port with the same request/grant handshake the Collector answers on the output side. It respects downstream full, counts completed injections, and gives every requester fair access.

---
 rtl/local_inject_arbiter_if.sv | 24 ++
 rtl/local_inject_arbiter.sv | 69 ++++++
 tb/tb_local_inject_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/local_inject_arbiter_if.sv
// local_inject_arbiter_if: source-side and router-side signals of the injection arbiter
`timescale 1ns/1ps
interface local_inject_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int packetwidth = 26
) ();
    logic [NUM_SRC-1:0]             SrcReq;
    logic [NUM_SRC*packetwidth-1:0] SrcPacket;
    logic [NUM_SRC-1:0]             SrcGnt;
    logic [packetwidth-1:0]         PacketOut;
    logic                           ReqDnStr;
    logic                           GntDnStr;
    logic                           DnStrFull;
    logic [15:0]                    SentCount;
    logic                           Busy;
    modport master (
        input  SrcReq, SrcPacket, GntDnStr, DnStrFull,
        output SrcGnt, PacketOut, ReqDnStr, SentCount, Busy
    );
    modport slave (
        output SrcReq, SrcPacket, GntDnStr, DnStrFull,
        input  SrcGnt, PacketOut, ReqDnStr, SentCount, Busy
    );
endinterface

// File: rtl/local_inject_arbiter.sv
// local_inject_arbiter: round-robin capture of one source packet at a time,
// held and offered to the router Local port until granted
`timescale 1ns/1ps
module local_inject_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int IDW = 2,
    parameter int packetwidth = 26
) (
    input logic clk,
    input logic reset,
    local_inject_arbiter_if.master bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state;
    logic [IDW-1:0] ptr, win_idx, win;
    logic hit;
    logic [packetwidth-1:0] win_pkt;
    int pos;
    // search starts one past the last completed source and wraps
    always_comb begin
        win = '0;
        hit = 1'b0;
        pos = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            pos = (int'(ptr) + k >= NUM_SRC) ? int'(ptr) + k - NUM_SRC : int'(ptr) + k;
            for (int i = 0; i < NUM_SRC; i++)
                if (!hit && pos == i && bus.SrcReq[i]) begin
                    win = IDW'(i);
                    hit = 1'b1;
                end
        end
    end
    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (win == IDW'(i)) win_pkt = bus.SrcPacket[i*packetwidth +: packetwidth];
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            ptr <= IDW'(NUM_SRC - 1);
            win_idx <= '0;
            bus.SrcGnt <= '0;
            bus.PacketOut <= '0;
            bus.ReqDnStr <= 1'b0;
            bus.SentCount <= '0;
            bus.Busy <= 1'b0;
        end else begin
            bus.SrcGnt <= '0;
            if (state == IDLE) begin
                if (hit) begin
                    state <= SEND;
                    bus.PacketOut <= win_pkt;
                    bus.SrcGnt <= NUM_SRC'(1) << win;
                    win_idx <= win;
                    bus.Busy <= 1'b1;
                    bus.ReqDnStr <= !bus.DnStrFull;
                end
            end else if (bus.ReqDnStr && bus.GntDnStr) begin
                // grant outranks a simultaneous full: the transfer already happened
                state <= IDLE;
                bus.ReqDnStr <= 1'b0;
                bus.Busy <= 1'b0;
                bus.SentCount <= bus.SentCount + 16'd1;
                ptr <= win_idx;
            end else
                bus.ReqDnStr <= !bus.DnStrFull;
        end
endmodule

// File: tb/tb_local_inject_arbiter.sv
// tb_local_inject_arbiter: directed vectors for round-robin order, stall,
// spurious/simultaneous grant, mid-send reset and counter wrap
`timescale 1ns/1ps
module tb_local_inject_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vecs = 0;
    int errs = 0;
    logic [25:0] pk [4];
    local_inject_arbiter_if #(.NUM_SRC(4), .packetwidth(26)) bus ();
    local_inject_arbiter #(.NUM_SRC(4), .IDW(2), .packetwidth(26)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic load_pk();
        bus.SrcPacket = {pk[3], pk[2], pk[1], pk[0]};
    endtask

    task automatic send(input logic [3:0] req, input logic [3:0] gnt, input logic [25:0] pkt);
        @(negedge clk) bus.SrcReq = req;
        @(negedge clk);
        chk("gnt", 32'(bus.SrcGnt), 32'(gnt));
        chk("pkt", 32'(bus.PacketOut), 32'(pkt));
        chk("busy", 32'(bus.Busy), 1);
        chk("req", 32'(bus.ReqDnStr), 1);
        bus.SrcReq = 4'b0000;
        bus.GntDnStr = 1'b1;
        @(negedge clk);
        bus.GntDnStr = 1'b0;
        chk("busy_done", 32'(bus.Busy), 0);
        chk("req_done", 32'(bus.ReqDnStr), 0);
        chk("gnt_done", 32'(bus.SrcGnt), 0);
    endtask

    initial begin
        pk[0] = 26'h0000011;
        pk[1] = 26'h2000022;
        pk[2] = 26'h1234533;
        pk[3] = 26'h3FFFF44;
        load_pk();
        bus.SrcReq = 4'b0000;
        bus.GntDnStr = 1'b0;
        bus.DnStrFull = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(bus.SrcGnt), 0);
        chk("rst_pkt", 32'(bus.PacketOut), 0);
        chk("rst_req", 32'(bus.ReqDnStr), 0);
        chk("rst_busy", 32'(bus.Busy), 0);
        chk("rst_cnt", 32'(bus.SentCount), 0);
        reset = 1'b1;
        send(4'b1111, 4'b0001, pk[0]);
        send(4'b1111, 4'b0010, pk[1]);
        send(4'b1111, 4'b0100, pk[2]);
        send(4'b1111, 4'b1000, pk[3]);
        send(4'b1111, 4'b0001, pk[0]);
        chk("cnt5", 32'(bus.SentCount), 5);
        pk[2] = 26'h0A54123;
        load_pk();
        send(4'b0100, 4'b0100, 26'h0A54123);
        chk("cnt6", 32'(bus.SentCount), 6);
        send(4'b1111, 4'b1000, pk[3]);
        chk("cnt7", 32'(bus.SentCount), 7);
        // full stall with a spurious grant while the request is low
        @(negedge clk);
        bus.SrcReq = 4'b0001;
        bus.DnStrFull = 1'b1;
        @(negedge clk);
        chk("stall_gnt", 32'(bus.SrcGnt), 32'b0001);
        chk("stall_busy", 32'(bus.Busy), 1);
        chk("stall_req0", 32'(bus.ReqDnStr), 0);
        bus.SrcReq = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            bus.GntDnStr = (c == 4);
            @(negedge clk);
            chk("stall_req", 32'(bus.ReqDnStr), 0);
            chk("stall_pkt", 32'(bus.PacketOut), 32'(pk[0]));
            chk("stall_busy", 32'(bus.Busy), 1);
        end
        bus.DnStrFull = 1'b0;
        @(negedge clk);
        chk("unstall_req", 32'(bus.ReqDnStr), 1);
        chk("stall_cnt", 32'(bus.SentCount), 7);
        bus.GntDnStr = 1'b1;
        bus.DnStrFull = 1'b1;
        @(negedge clk);
        chk("gf_busy", 32'(bus.Busy), 0);
        chk("gf_req", 32'(bus.ReqDnStr), 0);
        chk("gf_cnt", 32'(bus.SentCount), 8);
        bus.DnStrFull = 1'b0;
        @(negedge clk);
        chk("idle_spur_busy", 32'(bus.Busy), 0);
        chk("idle_spur_cnt", 32'(bus.SentCount), 8);
        chk("idle_spur_gnt", 32'(bus.SrcGnt), 0);
        bus.GntDnStr = 1'b0;
        // reset while a packet is held
        bus.SrcReq = 4'b0010;
        @(negedge clk);
        chk("mid_gnt", 32'(bus.SrcGnt), 32'b0010);
        chk("mid_busy", 32'(bus.Busy), 1);
        bus.SrcReq = 4'b0000;
        #2 reset = 1'b0;
        #1;
        chk("ar_gnt", 32'(bus.SrcGnt), 0);
        chk("ar_pkt", 32'(bus.PacketOut), 0);
        chk("ar_req", 32'(bus.ReqDnStr), 0);
        chk("ar_busy", 32'(bus.Busy), 0);
        chk("ar_cnt", 32'(bus.SentCount), 0);
        @(negedge clk) reset = 1'b1;
        send(4'b1000, 4'b1000, pk[3]);
        send(4'b1111, 4'b0001, pk[0]);
        chk("ar_cnt2", 32'(bus.SentCount), 2);
        // counter wrap from a preloaded value
        @(negedge clk) force bus.SentCount = 16'hFFFE;
        @(negedge clk) release bus.SentCount;
        chk("pre_cnt", 32'(bus.SentCount), 32'hFFFE);
        send(4'b0010, 4'b0010, pk[1]);
        chk("cnt_ffff", 32'(bus.SentCount), 32'hFFFF);
        send(4'b0100, 4'b0100, pk[2]);
        chk("cnt_wrap", 32'(bus.SentCount), 0);
        chk("wrap_busy", 32'(bus.Busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
